vend_change_scheduler: RTL and testbench

VEND_CHANGE_SCHEDULER -- requirements
Module: vend_change_scheduler

---
 rtl/vend_change_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_vend_change_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_change_scheduler.sv
// Greedy coin-change sequencer: one coin per SELECT/EJECT/WAIT_ACK round, done one cycle after the last SELECT.
// Waits on hopper_ack per coin; define CHANGE_JAM_DETECT_EN to time out silent hoppers and mark them jammed.
module vend_change_scheduler #(
    parameter int ACK_TIMEOUT = 15,
    parameter int INV_MAX     = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] change_amt,
    input  logic       change_valid,
    input  logic       refill_valid,
    input  logic [1:0] refill_sel,
    input  logic [5:0] refill_cnt,
    input  logic       hopper_ack,
    output logic [1:0] hopper_sel,
    output logic       hopper_eject,
    output logic       busy,
    output logic       done,
    output logic [6:0] shortfall,
    output logic [5:0] inv5,
    output logic [5:0] inv10,
    output logic [5:0] inv20,
    output logic [2:0] jam_flags
);

    if (INV_MAX < 1 || INV_MAX > 63 || ACK_TIMEOUT < 1) begin : g_bad_cfg
        $error("vend_change_scheduler: INV_MAX must be 1..63 and ACK_TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, DONE} state_t;

    state_t     state_q, state_d;
    logic [6:0] remaining_q, remaining_d;
    logic [6:0] shortfall_q, shortfall_d;
    logic [5:0] inv5_q, inv5_d, inv10_q, inv10_d, inv20_q, inv20_d;
    logic [1:0] sel_q, sel_d;
    logic [2:0] jam;

`ifdef CHANGE_JAM_DETECT_EN
    localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [2:0]       jam_q, jam_d;
    assign jam = jam_q;
`else
    assign jam = 3'b000;
`endif

    function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 7'(INV_MAX)) ? 6'(INV_MAX) : s[5:0];
    endfunction

    function automatic logic [6:0] coin_val(input logic [1:0] s);
        case (s)
            2'd1:    return 7'd5;
            2'd2:    return 7'd10;
            2'd3:    return 7'd20;
            default: return 7'd0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        shortfall_d = shortfall_q;
        inv5_d      = inv5_q;
        inv10_d     = inv10_q;
        inv20_d     = inv20_q;
        sel_d       = sel_q;
`ifdef CHANGE_JAM_DETECT_EN
        tmo_d       = tmo_q;
        jam_d       = jam_q;
`endif
        case (state_q)
            IDLE: begin
                if (refill_valid) begin
                    case (refill_sel)
                        2'd1:    inv5_d  = sat_add(inv5_q, refill_cnt);
                        2'd2:    inv10_d = sat_add(inv10_q, refill_cnt);
                        2'd3:    inv20_d = sat_add(inv20_q, refill_cnt);
                        default: ;
                    endcase
                end
                if (change_valid) begin
                    remaining_d = change_amt;
                    shortfall_d = '0;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                state_d = EJECT;
                if (remaining_q >= 7'd20 && inv20_q != '0 && !jam[2]) begin
                    sel_d = 2'd3;
                end else if (remaining_q >= 7'd10 && inv10_q != '0 && !jam[1]) begin
                    sel_d = 2'd2;
                end else if (remaining_q >= 7'd5 && inv5_q != '0 && !jam[0]) begin
                    sel_d = 2'd1;
                end else begin
                    sel_d       = 2'd0;
                    shortfall_d = remaining_q;
                    state_d     = DONE;
                end
            end
            EJECT: begin
                state_d = WAIT_ACK;
`ifdef CHANGE_JAM_DETECT_EN
                tmo_d   = '0;
`endif
            end
            WAIT_ACK: begin
                if (hopper_ack) begin
                    remaining_d = (remaining_q >= coin_val(sel_q)) ? remaining_q - coin_val(sel_q) : '0;
                    case (sel_q)
                        2'd1:    if (inv5_q  != '0) inv5_d  = inv5_q  - 6'd1;
                        2'd2:    if (inv10_q != '0) inv10_d = inv10_q - 6'd1;
                        2'd3:    if (inv20_q != '0) inv20_d = inv20_q - 6'd1;
                        default: ;
                    endcase
                    sel_d   = 2'd0;
                    state_d = SELECT;
                end
`ifdef CHANGE_JAM_DETECT_EN
                // A silent hopper is abandoned for this and every later request until reset.
                else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    case (sel_q)
                        2'd1:    jam_d[0] = 1'b1;
                        2'd2:    jam_d[1] = 1'b1;
                        2'd3:    jam_d[2] = 1'b1;
                        default: ;
                    endcase
                    sel_d   = 2'd0;
                    state_d = SELECT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            shortfall_q <= '0;
            inv5_q      <= '0;
            inv10_q     <= '0;
            inv20_q     <= '0;
            sel_q       <= '0;
`ifdef CHANGE_JAM_DETECT_EN
            tmo_q       <= '0;
            jam_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            shortfall_q <= shortfall_d;
            inv5_q      <= inv5_d;
            inv10_q     <= inv10_d;
            inv20_q     <= inv20_d;
            sel_q       <= sel_d;
`ifdef CHANGE_JAM_DETECT_EN
            tmo_q       <= tmo_d;
            jam_q       <= jam_d;
`endif
        end
    end

    assign hopper_sel   = (state_q == EJECT || state_q == WAIT_ACK) ? sel_q : 2'd0;
    assign hopper_eject = (state_q == EJECT);
    assign busy         = (state_q == SELECT || state_q == EJECT || state_q == WAIT_ACK);
    assign done         = (state_q == DONE);
    assign shortfall    = shortfall_q;
    assign inv5         = inv5_q;
    assign inv10        = inv10_q;
    assign inv20        = inv20_q;
    assign jam_flags    = jam;

endmodule

// File: tb/tb_vend_change_scheduler.sv
// Directed bench for vend_change_scheduler: coin sequences, shortfall, refill, busy lockout and reset abort.
module tb_vend_change_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] change_amt;
    logic       change_valid;
    logic       refill_valid;
    logic [1:0] refill_sel;
    logic [5:0] refill_cnt;
    logic       hopper_ack;
    logic [1:0] hopper_sel;
    logic       hopper_eject;
    logic       busy;
    logic       done;
    logic [6:0] shortfall;
    logic [5:0] inv5, inv10, inv20;
    logic [2:0] jam_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vend_change_scheduler #(.ACK_TIMEOUT(15), .INV_MAX(63)) dut (
        .clk          (clk),
        .reset        (reset),
        .change_amt   (change_amt),
        .change_valid (change_valid),
        .refill_valid (refill_valid),
        .refill_sel   (refill_sel),
        .refill_cnt   (refill_cnt),
        .hopper_ack   (hopper_ack),
        .hopper_sel   (hopper_sel),
        .hopper_eject (hopper_eject),
        .busy         (busy),
        .done         (done),
        .shortfall    (shortfall),
        .inv5         (inv5),
        .inv10        (inv10),
        .inv20        (inv20),
        .jam_flags    (jam_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic refill(input logic [1:0] sel, input logic [5:0] cnt);
        refill_valid = 1'b1;
        refill_sel   = sel;
        refill_cnt   = cnt;
        step();
        refill_valid = 1'b0;
        refill_sel   = 2'd0;
        refill_cnt   = 6'd0;
    endtask

    task automatic request(input logic [6:0] amt);
        change_amt   = amt;
        change_valid = 1'b1;
        step();
        change_valid = 1'b0;
        change_amt   = 7'd0;
    endtask

    // Acks each coin after ack_delay WAIT_ACK cycles (never for no_ack_sel);
    // seq packs the ejected hopper numbers two bits per coin, oldest first.
    task automatic serve(input int ack_delay, input logic [1:0] no_ack_sel,
                         output int seq, output int n_ej, output logic [6:0] sf);
        int         wait_cnt;
        logic [1:0] cur;
        logic       got_done;
        seq = 0; n_ej = 0; sf = '0; wait_cnt = 0; cur = 2'd0; got_done = 1'b0;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            @(negedge clk);
            hopper_ack = 1'b0;
            if (hopper_eject) begin
                seq = seq * 4 + int'(hopper_sel);
                n_ej++;
                cur = hopper_sel;
                wait_cnt = 0;
            end else if (cur != 2'd0) begin
                if (cur == no_ack_sel && hopper_sel == 2'd0) begin
                    cur = 2'd0;
                end else begin
                    chk("sel_hold", hopper_sel, cur);
                    if (cur != no_ack_sel && wait_cnt >= ack_delay) begin
                        hopper_ack = 1'b1;
                        cur = 2'd0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
            if (done) begin
                got_done = 1'b1;
                sf = shortfall;
                chk("busy_low_at_done", busy, 1'b0);
                chk("sel_zero_at_done", hopper_sel, 2'd0);
            end
        end
        hopper_ack = 1'b0;
        chk("done_within_budget", got_done, 1'b1);
        step();
    endtask

    int         seq, n_ej, done_seen;
    logic [6:0] sf;

    initial begin
        reset = 1'b1; change_amt = '0; change_valid = 1'b0; refill_valid = 1'b0;
        refill_sel = '0; refill_cnt = '0; hopper_ack = 1'b0;
        do_reset();

        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sel", hopper_sel, 2'd0);
        chk("rst_eject", hopper_eject, 1'b0);
        chk("rst_shortfall", shortfall, 7'd0);
        chk("rst_inv", {inv5, inv10, inv20}, 18'd0);
        chk("rst_jam", jam_flags, 3'd0);

        // Exact change 35 from 2/2/2
        refill(2'd1, 6'd2); refill(2'd2, 6'd2); refill(2'd3, 6'd2);
        refill(2'd0, 6'd9);
        chk("refill_inv5", inv5, 6'd2);
        chk("refill_inv10", inv10, 6'd2);
        chk("refill_inv20", inv20, 6'd2);
        hopper_ack = 1'b1; step(); hopper_ack = 1'b0;
        chk("ack_in_idle_ignored", inv5, 6'd2);
        request(7'd35);
        chk("busy_after_accept", busy, 1'b1);
        serve(0, 2'd0, seq, n_ej, sf);
        chk("exact_seq", seq, 32'd57);
        chk("exact_n", n_ej, 32'd3);
        chk("exact_sf", sf, 7'd0);
        chk("exact_inv", {inv5, inv10, inv20}, {6'd1, 6'd1, 6'd1});

        // Partial inventory 1/0/1, change 40
        do_reset();
        refill(2'd1, 6'd1); refill(2'd3, 6'd1);
        request(7'd40);
        serve(1, 2'd0, seq, n_ej, sf);
        chk("partial_seq", seq, 32'd13);
        chk("partial_sf", sf, 7'd15);
        chk("partial_inv", {inv5, inv10, inv20}, 18'd0);

        // Residue: 7 cents with 5c only, then zero-change request
        refill(2'd1, 6'd3);
        request(7'd7);
        serve(2, 2'd0, seq, n_ej, sf);
        chk("residue_seq", seq, 32'd1);
        chk("residue_sf", sf, 7'd2);
        chk("residue_inv5", inv5, 6'd2);
        step(); step();
        chk("shortfall_held", shortfall, 7'd2);
        request(7'd0);
        chk("zero_sf_cleared", shortfall, 7'd0);
        chk("zero_no_done_yet", done, 1'b0);
        step();
        chk("zero_done", done, 1'b1);
        chk("zero_no_eject", hopper_eject, 1'b0);
        chk("zero_sf", shortfall, 7'd0);
        step();
        chk("zero_done_single", done, 1'b0);

        // Saturating refill, then refill/change while busy are ignored
        refill(2'd3, 6'd60);
        chk("sat_first", inv20, 6'd60);
        refill(2'd3, 6'd60);
        chk("sat_second", inv20, 6'd63);
        request(7'd20);
        refill_valid = 1'b1; refill_sel = 2'd1; refill_cnt = 6'd5;
        change_valid = 1'b1; change_amt = 7'd100;
        serve(3, 2'd0, seq, n_ej, sf);
        refill_valid = 1'b0; refill_sel = 2'd0; refill_cnt = 6'd0;
        change_valid = 1'b0; change_amt = 7'd0;
        chk("busy_seq", seq, 32'd3);
        chk("busy_sf", sf, 7'd0);
        chk("busy_inv", {inv5, inv10, inv20}, {6'd2, 6'd0, 6'd62});
        chk("busy_back_idle", busy, 1'b0);

        // Refill coinciding with acceptance feeds SELECT
        do_reset();
        refill_valid = 1'b1; refill_sel = 2'd2; refill_cnt = 6'd1;
        request(7'd10);
        refill_valid = 1'b0; refill_sel = 2'd0; refill_cnt = 6'd0;
        serve(0, 2'd0, seq, n_ej, sf);
        chk("coincide_seq", seq, 32'd2);
        chk("coincide_sf", sf, 7'd0);
        chk("coincide_inv10", inv10, 6'd0);

`ifdef CHANGE_JAM_DETECT_EN
        // Silent 20c hopper: paid as 10,10 and 20c marked jammed
        do_reset();
        refill(2'd3, 6'd1); refill(2'd2, 6'd2);
        request(7'd20);
        serve(0, 2'd3, seq, n_ej, sf);
        chk("jam_seq", seq, 32'd58);
        chk("jam_sf", sf, 7'd0);
        chk("jam_flags", jam_flags, 3'b100);
        chk("jam_inv", {inv10, inv20}, {6'd0, 6'd1});
`endif

        // Reset while waiting for an ack
        do_reset();
        refill(2'd1, 6'd1);
        request(7'd5);
        step(); step();
        chk("wait_sel", hopper_sel, 2'd1);
        chk("wait_busy", busy, 1'b1);
`ifndef CHANGE_JAM_DETECT_EN
        repeat (30) step();
        chk("wait_forever_sel", hopper_sel, 2'd1);
        chk("wait_forever_jam", jam_flags, 3'd0);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_sel", hopper_sel, 2'd0);
        chk("abort_eject", hopper_eject, 1'b0);
        chk("abort_outs", {done, shortfall, inv5, jam_flags}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
